// File: rtl/data_mem_resp_pkg.sv
// Shared bus widths, lane numbering and access-class encoding for the data-memory responder.
package data_mem_resp_pkg;

    localparam int DATA_BUS    = 32;
    localparam int DATA_WE_BUS = 4;

    // Lane index by byte offset within the word: offset 0 lives in the top byte.
    localparam int LANE_B0 = 3;
    localparam int LANE_B1 = 2;
    localparam int LANE_B2 = 1;
    localparam int LANE_B3 = 0;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } acc_class_e;

    function automatic logic [DATA_BUS-1:0] lane_expand(input logic [DATA_WE_BUS-1:0] mask);
        logic [DATA_BUS-1:0] bits;
        bits = '0;
        for (int i = 0; i < DATA_WE_BUS; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/data_mem_resp_dram_bank.sv
// Single-port word array: byte-lane-enabled synchronous write, asynchronous read.
module dram_bank
    import data_mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                   clk,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [DATA_WE_BUS-1:0] wmask,
    input  logic [DATA_BUS-1:0]    wdata,
    output logic [DATA_BUS-1:0]    rdata
);

    logic [DATA_BUS-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_WE_BUS; i++) begin
            if (wmask[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: one-entry store buffer in front of a byte-lane array,
// with store-to-load forwarding and a registered, lane-masked load result.
module data_mem_resp
    import data_mem_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                   cpu_clk_50M,
    input  logic                   cpu_rst_n,
    input  logic [31:0]            daddr,
    input  logic                   dce,
    input  logic [DATA_WE_BUS-1:0] we,
    input  logic [DATA_WE_BUS-1:0] dre,
    input  logic [DATA_BUS-1:0]    din,
    output logic [DATA_BUS-1:0]    dm_dout,
    output logic                   sb_valid
);

    function automatic logic [DATA_BUS-1:0] merge_lanes(
        input logic [DATA_BUS-1:0]    base,
        input logic [DATA_BUS-1:0]    fwd,
        input logic [DATA_WE_BUS-1:0] mask
    );
        logic [DATA_BUS-1:0] m;
        m = lane_expand(mask);
        return (base & ~m) | (fwd & m);
    endfunction

    logic [ADDR_W-1:0]      word_idx;
    acc_class_e             acc;
    logic                   drain;
    logic [ADDR_W-1:0]      bank_addr;
    logic [DATA_WE_BUS-1:0] bank_wmask;
    logic [DATA_BUS-1:0]    bank_rdata;
    logic [DATA_BUS-1:0]    load_word;
    logic [DATA_BUS-1:0]    dout_next;
    logic                   sb_vld_next;

    logic                   sb_vld_p1;
    logic [ADDR_W-1:0]      sb_idx_p1;
    logic [DATA_WE_BUS-1:0] sb_mask_p1;
    logic [DATA_BUS-1:0]    sb_data_p1;
    logic [DATA_BUS-1:0]    dout_p1;

    // Byte offset and bits above the array depth are don't-care (addresses alias).
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, daddr[31:ADDR_W+2], daddr[1:0]};

    assign word_idx = daddr[ADDR_W+1:2];

    always_comb begin
        acc = ACC_IDLE;
        if (dce) begin
            if (we != '0) begin
                acc = ACC_STORE;
            end else if (dre != '0) begin
                acc = ACC_LOAD;
            end
        end
    end

    // A load owns the single array port; every other cycle is free to drain the buffer.
    assign drain      = sb_vld_p1 && (acc != ACC_LOAD);
    assign bank_addr  = drain ? sb_idx_p1 : word_idx;
    assign bank_wmask = drain ? sb_mask_p1 : '0;

    dram_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (cpu_clk_50M),
        .addr  (bank_addr),
        .wmask (bank_wmask),
        .wdata (sb_data_p1),
        .rdata (bank_rdata)
    );

    always_comb begin
        load_word = bank_rdata;
        if (sb_vld_p1 && (sb_idx_p1 == word_idx)) begin
            load_word = merge_lanes(bank_rdata, sb_data_p1, sb_mask_p1);
        end
        dout_next = (acc == ACC_LOAD) ? (load_word & lane_expand(dre)) : '0;

        sb_vld_next = sb_vld_p1;
        if (acc == ACC_STORE) begin
            sb_vld_next = 1'b1;
        end else if (acc == ACC_IDLE) begin
            sb_vld_next = 1'b0;
        end
    end

    // ---- stage p1: store buffer and load result register ----
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            sb_vld_p1 <= 1'b0;
            dout_p1   <= '0;
        end else begin
            sb_vld_p1 <= sb_vld_next;
            dout_p1   <= dout_next;
        end
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (acc == ACC_STORE) begin
            sb_idx_p1  <= word_idx;
            sb_mask_p1 <= we;
            sb_data_p1 <= din;
        end
    end

    assign dm_dout  = dout_p1;
    assign sb_valid = sb_vld_p1;

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp: hand-computed vector table, reset corner case,
// and a randomized phase checked against an immediate-write memory model via a scoreboard.
module tb_data_mem_resp;

    localparam int AW = 10;

    logic        clk;
    logic        rst_n;
    logic [31:0] daddr;
    logic        dce;
    logic [3:0]  we;
    logic [3:0]  dre;
    logic [31:0] din;
    logic [31:0] dm_dout;
    logic        sb_valid;

    data_mem_resp #(.ADDR_W(AW)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .daddr       (daddr),
        .dce         (dce),
        .we          (we),
        .dre         (dre),
        .din         (din),
        .dm_dout     (dm_dout),
        .sb_valid    (sb_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        dce;
        logic [3:0]  we;
        logic [3:0]  dre;
        logic [31:0] addr;
        logic [31:0] din;
        logic [31:0] exp_dout;
        logic        exp_sbv;
    } vec_t;

    typedef struct packed {
        logic [31:0] dout;
        logic        sbv;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mdl_mem [0:(1<<AW)-1];
    logic        mdl_pend = 1'b0;
    vec_t        vecs[24];

    function automatic logic [31:0] expand(input logic [3:0] m);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction

    function automatic vec_t mkv(input logic d, input logic [3:0] w, input logic [3:0] r,
                                 input logic [31:0] a, input logic [31:0] di,
                                 input logic [31:0] ed, input logic es);
        vec_t v;
        v.dce = d; v.we = w; v.dre = r; v.addr = a; v.din = di;
        v.exp_dout = ed; v.exp_sbv = es;
        return v;
    endfunction

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    // One clock cycle of traffic; the model treats stores as visible immediately.
    task automatic do_cycle(input logic d, input logic [3:0] w, input logic [3:0] r,
                            input logic [31:0] a, input logic [31:0] di,
                            input logic fixed, input logic [31:0] fd, input logic fs,
                            input string nm);
        exp_t        e;
        exp_t        got;
        logic [31:0] md;
        logic [AW-1:0] idx;
        idx = a[AW+1:2];
        md  = '0;
        if (d && w != 4'b0) begin
            for (int i = 0; i < 4; i++)
                if (w[i]) mdl_mem[idx][8*i +: 8] = di[8*i +: 8];
            mdl_pend = 1'b1;
        end else if (d && r != 4'b0) begin
            md = mdl_mem[idx] & expand(r);
        end else begin
            mdl_pend = 1'b0;
        end
        if (fixed) begin
            e.dout = fd; e.sbv = fs;
        end else begin
            e.dout = md; e.sbv = mdl_pend;
        end
        dce = d; we = w; dre = r; daddr = a; din = di;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            got = sb_q.pop_front();
            chk32({nm, ".dout"}, dm_dout, got.dout);
            chk1({nm, ".sbv"}, sb_valid, got.sbv);
        end
    endtask

    initial begin
        logic [31:0] bases[4];
        bases[0] = 32'h20; bases[1] = 32'h30; bases[2] = 32'h40; bases[3] = 32'h50;

        vecs[0]  = mkv(1, 4'hF, 4'h0, 32'h20,   32'h11223344, 32'h0,        1);
        vecs[1]  = mkv(0, 4'h0, 4'h0, 32'h20,   32'h0,        32'h0,        0);
        vecs[2]  = mkv(1, 4'h0, 4'hF, 32'h20,   32'h0,        32'h11223344, 0);
        vecs[3]  = mkv(1, 4'h4, 4'h0, 32'h21,   32'h00EE0000, 32'h0,        1);
        vecs[4]  = mkv(1, 4'h0, 4'hF, 32'h20,   32'h0,        32'h11EE3344, 1);
        vecs[5]  = mkv(0, 4'h0, 4'h0, 32'h0,    32'h0,        32'h0,        0);
        vecs[6]  = mkv(1, 4'h0, 4'h2, 32'h20,   32'h0,        32'h00003300, 0);
        vecs[7]  = mkv(0, 4'h0, 4'h0, 32'h0,    32'h0,        32'h0,        0);
        vecs[8]  = mkv(1, 4'h8, 4'h0, 32'h30,   32'hAA000000, 32'h0,        1);
        vecs[9]  = mkv(1, 4'h8, 4'h0, 32'h30,   32'hBB000000, 32'h0,        1);
        vecs[10] = mkv(1, 4'h0, 4'h8, 32'h30,   32'h0,        32'hBB000000, 1);
        vecs[11] = mkv(0, 4'h0, 4'h0, 32'h0,    32'h0,        32'h0,        0);
        vecs[12] = mkv(1, 4'h0, 4'h8, 32'h30,   32'h0,        32'hBB000000, 0);
        vecs[13] = mkv(1, 4'hF, 4'hF, 32'h40,   32'hCAFEF00D, 32'h0,        1);
        vecs[14] = mkv(0, 4'h0, 4'h0, 32'h0,    32'h0,        32'h0,        0);
        vecs[15] = mkv(1, 4'hF, 4'h0, 32'h1040, 32'h12345678, 32'h0,        1);
        vecs[16] = mkv(1, 4'h0, 4'hF, 32'h40,   32'h0,        32'h12345678, 1);
        vecs[17] = mkv(0, 4'h0, 4'h0, 32'h0,    32'h0,        32'h0,        0);
        vecs[18] = mkv(1, 4'h0, 4'hF, 32'h43,   32'h0,        32'h12345678, 0);
        vecs[19] = mkv(0, 4'hF, 4'hF, 32'h40,   32'hDEADBEEF, 32'h0,        0);
        vecs[20] = mkv(1, 4'h0, 4'hF, 32'h40,   32'h0,        32'h12345678, 0);
        vecs[21] = mkv(1, 4'hF, 4'h0, 32'h50,   32'h55667788, 32'h0,        1);
        vecs[22] = mkv(0, 4'hF, 4'h0, 32'h50,   32'h0,        32'h0,        0);
        vecs[23] = mkv(1, 4'h0, 4'h6, 32'h50,   32'h0,        32'h00667700, 0);

        rst_n = 1'b0; dce = 1'b0; we = '0; dre = '0; daddr = '0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        chk32("reset.dout", dm_dout, 32'h0);
        chk1("reset.sbv", sb_valid, 1'b0);
        rst_n = 1'b1;

        // Store into the buffer, then reset before it can drain.
        do_cycle(1, 4'hF, 4'h0, 32'h10, 32'hAABBCCDD, 1, 32'h0, 1'b1, "rst_store");
        dce = 1'b0; we = '0;
        #2;
        rst_n = 1'b0;
        #1;
        chk1("rst_mid.sbv", sb_valid, 1'b0);
        chk32("rst_mid.dout", dm_dout, 32'h0);
        @(posedge clk);
        #1;
        chk1("rst_hold.sbv", sb_valid, 1'b0);
        rst_n = 1'b1;
        mdl_pend = 1'b0;
        dce = 1'b1; we = 4'h0; dre = 4'hF; daddr = 32'h10;
        @(posedge clk);
        #1;
        n_cmp++;
        if (dm_dout === 32'hAABBCCDD) begin
            n_err++;
            $display("FAIL rst_discard: got %h, required anything but aabbccdd", dm_dout);
        end

        for (int i = 0; i < 24; i++) begin
            do_cycle(vecs[i].dce, vecs[i].we, vecs[i].dre, vecs[i].addr, vecs[i].din,
                     1, vecs[i].exp_dout, vecs[i].exp_sbv, $sformatf("vec%0d", i));
        end

        for (int k = 0; k < 4; k++) begin
            do_cycle(1, 4'hF, 4'h0, bases[k], $urandom, 0, 32'h0, 1'b0,
                     $sformatf("rinit%0d", k));
        end
        for (int n = 0; n < 120; n++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 4);
            a = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = a + 32'h1000;
            case (kind)
                0: do_cycle(0, 4'($urandom), 4'($urandom), a, $urandom, 0, 32'h0, 1'b0,
                            $sformatf("rnd%0d", n));
                1, 2: do_cycle(1, 4'h0, 4'($urandom_range(1, 15)), a, $urandom, 0, 32'h0, 1'b0,
                               $sformatf("rnd%0d", n));
                3: do_cycle(1, 4'($urandom_range(1, 15)), 4'h0, a, $urandom, 0, 32'h0, 1'b0,
                            $sformatf("rnd%0d", n));
                default: do_cycle(1, 4'($urandom_range(1, 15)), 4'hF, a, $urandom, 0, 32'h0,
                                  1'b0, $sformatf("rnd%0d", n));
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder at the far end of the pipeline's data port: accepts the per-cycle access (`daddr`, `dce`, `we`, `dre`, `din`) driven by the memory stage and returns load data one cycle later, in time for write-back. Storage is a single-port, byte-lane-enabled word array fronted by a one-entry store buffer. Stores retire into the buffer without stalling. Loads read the array and merge in any pending buffered bytes (store-to-load forwarding).

## Interface
- `ADDR_W`, default 10: word-index width; array depth is 2^ADDR_W words.
- `cpu_clk_50M`  in  1  clock; all state changes on the rising edge.
- `cpu_rst_n`  in  1  reset; asynchronous assert, active-low.
- `daddr`  in  32  byte address; `daddr[ADDR_W+1:2]` selects the word; `daddr[1:0]` and upper bits are ignored (upper bits alias).
- `dce`  in  1  access enable; when 0, `we`, `dre` and `din` are ignored.
- `we`  in  4  store byte-lane enables; lane 3 = byte offset 0, lane 0 = offset 3.
- `dre`  in  4  load byte-lane enables; same lane mapping as `we`.
- `din`  in  32  store data, already lane-ordered: `din[31:24]` is lane 3.
- `dm_dout`  out  32  registered load data, lane-ordered; lanes not enabled by the load are 0.
- `sb_valid`  out  1  store buffer holds an undrained store (observability only).

## Operation
- Access classes per cycle:
  - LOAD: `dce` = 1, `we` = 0, `dre` ≠ 0.
  - STORE: `dce` = 1, `we` ≠ 0; `we` takes priority, and any `dre` in the same cycle is ignored.
  - IDLE: everything else.
- Store buffer holds {valid, word index, 4-bit lane mask, 32-bit data}.
- STORE cycle:
  - If the buffer is valid, it drains into the array this edge (the array port is free).
  - The new store is captured into the buffer. The buffer ends valid.
- IDLE cycle: if the buffer is valid, it drains into the array and becomes invalid.
- LOAD cycle:
  - The array port reads the addressed word; the buffer does not drain and keeps its contents.
  - If the buffer is valid and the word index matches, each lane set in the buffer mask is replaced by the buffered byte.
  - The merged word is ANDed with the lane mask expanded from `dre`, then registered into `dm_dout`.
- Drain writes only the lanes in the buffer mask; all other lanes of the array word are unchanged.
- Back-to-back stores to the same word: the older store drains on the same edge the newer one is captured, so the array ends with the older bytes and the buffer holds the newer bytes. A following load sees the newer bytes through the merge.
- An unbounded run of loads keeps the buffer pending indefinitely; correctness is maintained by the merge.

## Timing
- Reset (asynchronous, `cpu_rst_n` = 0): `dm_dout` = 0, `sb_valid` = 0, buffer invalid. Array contents are not reset.
- Reset asserted while a store is buffered: that store is discarded and never reaches the array.
- Load latency is 1: a load presented in cycle N appears on `dm_dout` after edge N+1 and stays until the next edge.
- `dm_dout` updates every edge. Any non-LOAD cycle registers 0.
- Store visibility to a subsequent load is 0 cycles, via the merge.
- `sb_valid` rises on the edge that captures a store. It falls on the edge of the first subsequent IDLE cycle, unless another store is captured.

## Structure
- Shared package holds:
  - `DATA_BUS` (32).
  - `DATA_WE_BUS` (4).
  - Lane-index constants: `LANE_B0` = 3 … `LANE_B3` = 0.
  - Access-class encoding (IDLE/LOAD/STORE).
- Sub-module `dram_bank`: single-port, synchronous-write, byte-lane-enabled array (`ADDR_W`, one address, 4-bit write mask, 32-bit data). It has an asynchronous read port so the merge and register fit in one cycle.
- The top level holds the access classifier, store buffer, merge/mask logic and the `dm_dout` register.

## Test plan
- Reset mid-store: STORE `daddr`=0x10, `we`=4'b1111, `din`=0xAABBCCDD, then reset before any IDLE cycle; after reset, LOAD 0x10 with `dre`=1111 -> `dm_dout` is not 0xAABBCCDD, and `sb_valid`=0 during reset.
- Write/idle/read: STORE 0x20, `we`=1111, `din`=0x11223344; IDLE; LOAD 0x20, `dre`=1111 -> `dm_dout`=0x11223344 one cycle after the load; `sb_valid` 1→0 across the IDLE.
- Forwarding: STORE 0x20, `we`=1111, `din`=0x11223344; IDLE; STORE 0x21, `we`=0100, `din`=0x00EE0000; immediately LOAD 0x20, `dre`=1111 -> `dm_dout`=0x11EE3344 with `sb_valid` still 1.
- Lane masking: with word 0x20 = 0x11223344, LOAD with `dre`=0010 -> `dm_dout`=0x00003300; the next IDLE cycle gives `dm_dout`=0.
- Back-to-back same-word stores: STORE 0x30 `we`=1000 `din`=0xAA000000; STORE 0x30 `we`=1000 `din`=0xBB000000; LOAD 0x30 `dre`=1000 -> 0xBB000000; IDLE; LOAD again -> 0xBB000000.
- Priority and aliasing: STORE and `dre`=1111 together with `dce`=1 -> treated as STORE and `dm_dout`=0 next cycle; STORE to `daddr`=0x40 + (2^(ADDR_W+2)) is readable at 0x40; any traffic with `dce`=0 changes no state.
